// File: rtl/tag_arb_pkg.sv
// Shared types and helpers for the tag stream arbiter.
// Holds the FSM state encoding, the inter-frame gap length and a
// constant-evaluable log2 used to size pointers and counters.
package tag_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Cycles the output stays quiet after a frame so the buffer can write
    // its tag trailer without a competing beat.
    localparam int GAP_CYCLES = 1;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tag_stream_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns a one-hot grant for the first requesting index at or after ptr,
// wrapping past N-1 back to 0, plus a flag saying any request is present.
module rr_pick
    import tag_arb_pkg::*;
#(
    parameter int N     = 10,
    parameter int PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any_req
);

    // Walk the N positions starting at ptr and grant the first requester.
    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/tag_stream_arb.sv
// tag_stream_arb: round-robin frame arbiter in front of the tag data buffer.
// One tag owns the write port for a whole frame; after its tlast the port
// goes quiet for a gap cycle, then re-arbitrates from the tag after the
// last winner. m_axis_tuser carries the one-hot owner for the trailer.
// Optional feature macro: TAG_ARB_TIMEOUT_EN (forced close of a stalled frame
// after TIMEOUT idle cycles; adds the TIMEOUT parameter).
//
// Handshake: a beat moves on a port exactly in a cycle where its valid and
// ready are both 1 at the rising clock edge; valid never waits on ready, and
// the payload is held stable while valid is high and ready is low.
module tag_stream_arb
    import tag_arb_pkg::*;
#(
    parameter int NUM_TAGS   = 10,
    parameter int DATA_WIDTH = 256
`ifdef TAG_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 1023
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_TAGS-1:0]            s_axis_tvalid,
    output logic [NUM_TAGS-1:0]            s_axis_tready,
    input  logic [NUM_TAGS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_TAGS-1:0]            s_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [NUM_TAGS-1:0]            m_axis_tuser,
    output logic                           m_axis_tlast,
    output logic                           frame_done,
    output logic                           frame_abort,
    output logic                           busy,
    output logic [1:0]                     state_dbg
);

    localparam int PTR_W = clog2(NUM_TAGS);

    arb_state_e            state_q, state_d;
    logic [NUM_TAGS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [1:0]            gap_q;
    logic                  frame_done_q;

    logic [NUM_TAGS-1:0]   pick_gnt;
    logic                  any_req;
    logic [PTR_W-1:0]      g_idx;
    logic [PTR_W-1:0]      ptr_after_g;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  xfer;
    logic                  forced;
    logic                  beat_hs;
    logic                  last_hs;

    rr_pick #(
        .N     (NUM_TAGS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (s_axis_tvalid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .any_req (any_req)
    );

    assign xfer    = (state_q == ST_XFER);
    assign g_valid = |(s_axis_tvalid & grant_q);
    assign g_last  = |(s_axis_tlast & grant_q);

    // Data mux on the registered one-hot grant; no pipeline stage added.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (grant_q[i]) begin
                g_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Encode the granted tag index so the pointer can move past it.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (grant_q[i]) begin
                g_idx = PTR_W'(i);
            end
        end
    end

    assign ptr_after_g = (g_idx == PTR_W'(NUM_TAGS - 1)) ? '0 : g_idx + PTR_W'(1);

    // Output side: the granted stream passes straight through during XFER;
    // a forced close substitutes a zero-data tlast beat and blocks the source.
    always_comb begin
        m_axis_tvalid = xfer & (g_valid | forced);
        m_axis_tdata  = (xfer && !forced) ? g_data : '0;
        m_axis_tlast  = xfer & (g_last | forced);
        m_axis_tuser  = xfer ? grant_q : '0;
        s_axis_tready = (xfer && !forced && m_axis_tready) ? grant_q : '0;
    end

    assign beat_hs = m_axis_tvalid & m_axis_tready;
    assign last_hs = beat_hs & m_axis_tlast;

    // Next-state logic: pick in IDLE, hold through the frame, one gap, repeat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = pick_gnt;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (last_hs) begin
                    grant_d = '0;
                    ptr_d   = ptr_after_g;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == 2'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and completion pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            frame_done_q <= last_hs & ~forced;
        end
    end

    // Gap cycle counter; only runs while in GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (state_q == ST_GAP) begin
            gap_q <= gap_q + 2'd1;
        end else begin
            gap_q <= '0;
        end
    end

`ifdef TAG_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_q;
    logic             frame_abort_q;

    assign forced = xfer && (stall_q == CNT_W'(TIMEOUT));

    // Count XFER cycles with the owner idle; any accepted beat restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!xfer || beat_hs) begin
            stall_q <= '0;
        end else if (!g_valid && !forced) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Abort pulse follows acceptance of the forced closing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_abort_q <= 1'b0;
        end else begin
            frame_abort_q <= last_hs & forced;
        end
    end

    assign frame_abort = frame_abort_q;
`else
    assign forced      = 1'b0;
    assign frame_abort = 1'b0;
`endif

    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_tag_stream_arb.sv
// Bench for tag_stream_arb: per-tag frame sources, a rotation model that
// predicts the beat stream, and a monitor that pops and compares.
module tb_tag_stream_arb;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int EW = N + DW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N-1:0]      s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [N-1:0]      m_axis_tuser;
    logic              m_axis_tlast;
    logic              frame_done;
    logic              frame_abort;
    logic              busy;
    logic [1:0]        state_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    tag_stream_arb #(
        .NUM_TAGS   (N),
        .DATA_WIDTH (DW)
`ifdef TAG_ARB_TIMEOUT_EN
        ,
        .TIMEOUT    (15)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];          // {tuser, tlast, tdata}
    bit mon_en    = 1'b0;
    bit prev_last = 1'b0;

    // source state
    int            len_q[N][$];
    logic [DW-1:0] seed_q[N][$];
    bit            active[N];
    int            beat[N];
    int            cur_len[N];
    logic [DW-1:0] cur_seed[N];
    int            stall_left[N];
    int            model_ptr   = 0;
    int            tready_mode = 0;   // 0: always 1, 1: random, 2: toggle
    bit            tog         = 1'b0;
    bit            rand_gaps   = 1'b0;
    int            gap_tag     = -1;
    int            gap_beat    = 0;
    int            gap_len     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] seed, input int b);
        return seed + DW'(b) * 32'h9E37_79B9;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic add_frame(input int t, input int len);
        len_q[t].push_back(len);
        seed_q[t].push_back($urandom);
    endtask

    // Reference: pending frames are served strictly in rotation from the
    // tag after the last winner; each frame's beats appear contiguously.
    task automatic build_expect();
        int idx[N];
        int left;
        int t;
        left = 0;
        for (int i = 0; i < N; i++) begin
            idx[i] = 0;
            left += len_q[i].size();
        end
        while (left > 0) begin
            t = -1;
            for (int k = 0; k < N; k++) begin
                if (t < 0 && idx[(model_ptr + k) % N] < len_q[(model_ptr + k) % N].size())
                    t = (model_ptr + k) % N;
            end
            for (int b = 0; b < len_q[t][idx[t]]; b++) begin
                exp_q.push_back({N'(1 << t), (b == len_q[t][idx[t]] - 1),
                                 beat_data(seed_q[t][idx[t]], b)});
            end
            idx[t]++;
            left--;
            model_ptr = (t + 1) % N;
        end
    endtask

    task automatic step(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) begin
            if (active[i] && acc[i]) begin
                beat[i]++;
                if (beat[i] == cur_len[i]) begin
                    active[i] = 1'b0;
                end else if (i == gap_tag && beat[i] == gap_beat) begin
                    stall_left[i] = gap_len;
                end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                    stall_left[i] = $urandom_range(1, 5);
                end else begin
                    stall_left[i] = 0;
                end
            end
            if (!active[i] && len_q[i].size() > 0) begin
                active[i]     = 1'b1;
                beat[i]       = 0;
                cur_len[i]    = len_q[i].pop_front();
                cur_seed[i]   = seed_q[i].pop_front();
                stall_left[i] = 0;
            end
            if (active[i] && stall_left[i] == 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*DW +: DW]  = beat_data(cur_seed[i], beat[i]);
                s_axis_tlast[i]           = (beat[i] == cur_len[i] - 1);
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW]  = '0;
                s_axis_tlast[i]           = 1'b0;
            end
            if (stall_left[i] > 0) stall_left[i]--;
        end
        case (tready_mode)
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       begin tog = ~tog; m_axis_tready = tog; end
            default: m_axis_tready = 1'b1;
        endcase
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() > 0);
        for (int i = 0; i < N; i++) if (active[i] || len_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_scenario(input string name);
        logic [N-1:0] acc;
        int cyc;
        build_expect();
        @(posedge clk); #1;
        step('0);
        cyc = 0;
        while (pending() && cyc < 4000) begin
            @(negedge clk);
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge clk); #1;
            step(acc);
            cyc++;
        end
        if (cyc >= 4000) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), cyc);
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                len_q[i].delete();
                seed_q[i].delete();
                active[i] = 1'b0;
            end
            s_axis_tvalid = '0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_ptr = 0;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int budget, output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (!ok && c < budget) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) ok = 1'b1;
            c++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (mon_en) begin
            if (prev_last) begin
                check("frame_done_pulse", 64'(frame_done), 64'd1);
                check("gap_quiet", 64'(m_axis_tvalid), 64'd0);
            end else begin
                check("frame_done_low", 64'(frame_done), 64'd0);
            end
            check("tready_only_granted", 64'(s_axis_tready & ~m_axis_tuser), 64'd0);
            check("tuser_onehot", 64'($countones(m_axis_tuser) <= 1), 64'd1);
            if (m_axis_tvalid && m_axis_tready) begin
                got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(got), 64'(e));
                end
                prev_last = m_axis_tlast;
            end else begin
                prev_last = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int hs;
        int cyc;
        int stall;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0;
            beat[i] = 0;
            cur_len[i] = 0;
            cur_seed[i] = '0;
            stall_left[i] = 0;
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_abort", 64'(frame_abort), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_m_tvalid", 64'(m_axis_tvalid), 64'd0);

        mon_en = 1'b1;
        prev_last = 1'b0;

        // simultaneous requests 0,5,9 with 5 re-requesting; tag 9 single beat
        tready_mode = 0;
        add_frame(0, 3);
        add_frame(5, 2);
        add_frame(5, 4);
        add_frame(9, 1);
        run_scenario("rotation");

        // tag 3 alone, 4 beats, tready held high
        add_frame(3, 4);
        run_scenario("single_tag");

        // 8-beat frame with tready toggling every cycle
        tready_mode = 2;
        add_frame(1, 8);
        run_scenario("tready_toggle");

        // owner 2 stalls 20 cycles mid-frame while tag 7 waits
        tready_mode = 0;
        gap_tag = 2; gap_beat = 2; gap_len = 20;
        add_frame(2, 6);
        add_frame(7, 3);
        run_scenario("owner_stall");
        gap_tag = -1;

        // random mixes with backpressure and source gaps
        tready_mode = 1;
        rand_gaps = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int t = 0; t < N; t++) begin
                for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
                    add_frame(t, $urandom_range(1, 6));
                end
            end
            run_scenario("random");
        end
        rand_gaps = 1'b0;
        tready_mode = 0;
        mon_en = 1'b0;

`ifdef TAG_ARB_TIMEOUT_EN
        // stalled owner is closed by a forced zero-data tlast beat
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = {N{32'hA5A5_5A5A}};
        m_axis_tready = 1'b1;
        s_axis_tvalid[2] = 1'b1;
        wait_hs(50, ok);
        check("to_first_beat", 64'(ok), 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid[2] = 1'b0;
        s_axis_tvalid[8] = 1'b1;
        stall = 0;
        @(negedge clk);
        while (!m_axis_tvalid && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        check("to_stall_cycles", 64'(stall), 64'd15);
        check("to_tdata", 64'(m_axis_tdata), 64'd0);
        check("to_tlast", 64'(m_axis_tlast), 64'd1);
        check("to_tuser", 64'(m_axis_tuser), 64'h004);
        check("to_s_tready", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        check("to_abort", 64'(frame_abort), 64'd1);
        check("to_no_done", 64'(frame_done), 64'd0);
        check("to_gap", 64'(m_axis_tvalid), 64'd0);
        cyc = 0;
        @(negedge clk);
        while (!m_axis_tvalid && cyc < 5) begin
            cyc++;
            @(negedge clk);
        end
        check("to_next_grant", 64'(m_axis_tuser), 64'h100);
        @(posedge clk); #1;
        s_axis_tvalid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        // reset mid-frame: grant drops at once, restart picks the lowest tag
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = $urandom | 32'h1;
        m_axis_tready = 1'b1;
        s_axis_tvalid[1] = 1'b1;
        hs = 0;
        cyc = 0;
        while (hs < 2 && cyc < 50) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) hs++;
            cyc++;
        end
        check("mid_rst_beats_before", 64'(hs), 64'd2);
        @(posedge clk); #1;
        s_axis_tvalid[4] = 1'b1;
        s_axis_tvalid[6] = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_m_tuser", 64'(m_axis_tuser), 64'd0);
        check("mid_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("mid_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        s_axis_tvalid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_grant", 64'(m_axis_tuser), 64'h010);
        check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
